// File: rtl/chroni_line_writer_if.sv
// Row request, pixel stream and line buffer write port of the line writer.
// Latency: n/a (signal bundle only).
// Backpressure: src_valid/src_ready handshake; the buffer write port has none.
//
// Signals:
//   row_start, row_index        writer -> renderer, begin row row_index
//   src_data, src_valid         renderer -> writer, pixel stream
//   src_ready                   writer -> renderer, pixel accepted when both high
//   buf_we, buf_addr, buf_data  writer -> line buffer, one write per accepted pixel
// Modports: master = renderer / line buffer side, slave = line writer.
interface chroni_line_writer_if #(
   parameter int ADDR_W = 11
);
   logic              row_start;
   logic [7:0]        row_index;
   logic [7:0]        src_data;
   logic              src_valid;
   logic              src_ready;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_data;

   modport master (
      output src_data, src_valid,
      input  row_start, row_index, src_ready, buf_we, buf_addr, buf_data
   );

   modport slave (
      input  src_data, src_valid,
      output row_start, row_index, src_ready, buf_we, buf_addr, buf_data
   );
endinterface

// File: rtl/chroni_line_writer.sv
// Fills the VGA double line buffer one row at a time from an upstream pixel stream.
// Latency: line buffer write lands exactly 1 cycle after each accepted pixel.
// Backpressure: src_ready is high only while filling a row; late rows raise overrun.
//
// Ports:
//   sys_clk, reset_n      clock, asynchronous active-low reset
//   frame_start           pulse, abort rendering and clear overrun state
//   render_start          pulse, prime rows 0 and 1 into buffers 0 and 1
//   scanline_start        pulse, one per VGA line; P of them make one row period
//   pixel_scale           level, P = 4 when high, 2 when low (sampled at render_start)
//   lw (slave)            row request, pixel stream and line buffer write port
//   busy                  writer is not idle
//   overrun               sticky, a row period ended before its row was written
//   overrun_count         only with CHRONI_LINE_WRITER_OVERRUN_CNT_EN: saturating
//                         count of late row periods, cleared by frame_start
module chroni_line_writer #(
   parameter int LINE_WIDTH = 640,
   parameter int ROWS       = 240,
   parameter int ADDR_W     = 11
) (
   input  logic                sys_clk,
   input  logic                reset_n,
   input  logic                frame_start,
   input  logic                render_start,
   input  logic                scanline_start,
   input  logic                pixel_scale,
   chroni_line_writer_if.slave lw,
   output logic                busy,
   output logic                overrun
`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
   ,
   output logic [7:0]          overrun_count
`endif
);

   localparam int                X_W       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [X_W-1:0]    X_LAST    = X_W'(LINE_WIDTH - 1);
   localparam logic [7:0]        ROW_END   = 8'(ROWS);
   localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(LINE_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_FILL,
      ST_WAIT
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [X_W-1:0]    x;
   logic              wbuf;
   logic [7:0]        row;
   logic [7:0]        row_inc;
   logic [1:0]        sl_cnt;
   logic              scale_q;
   logic              pending;
   logic              pending_nxt;
   logic              prime;
   logic              prime_nxt;

   logic              buf_we_q;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [7:0]        buf_data_q;

   logic              hs;
   logic              row_done;
   logic              sl_tick;
   logic              trig;
   logic              late_trig;
   logic              frame_clr;

   assign hs       = lw.src_valid && (state == ST_FILL);
   assign row_done = hs && (x == X_LAST);
   assign row_inc  = row + 8'd1;

   // A scanline that coincides with render_start is swallowed by the restart.
   assign sl_tick  = scanline_start && (state != ST_IDLE) && !render_start;
   assign trig     = sl_tick && (sl_cnt == (scale_q ? 2'd3 : 2'd1));

   // render_start outranks frame_start, so a combined pulse does not clear anything.
   assign frame_clr = frame_start && !render_start;

   // A period ending while a row is still being requested or filled is late.
   assign late_trig = trig && !frame_clr && ((state == ST_START) || (state == ST_FILL));

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      prime_nxt   = prime;
      if (render_start) begin
         state_nxt   = ST_START;
         pending_nxt = 1'b0;
         prime_nxt   = 1'b1;
      end else if (frame_start) begin
         state_nxt   = ST_IDLE;
         pending_nxt = 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_START: begin
               state_nxt = ST_FILL;
               if (trig) pending_nxt = 1'b1;
            end
            ST_FILL: begin
               if (trig) pending_nxt = 1'b1;
               if (row_done) begin
                  if (row_inc == ROW_END) begin
                     state_nxt = ST_IDLE;
                  end else if (prime) begin
                     // second priming row goes straight out; a late period stays pending
                     prime_nxt = 1'b0;
                     state_nxt = ST_START;
                  end else if (pending || trig) begin
                     // a period already ended during this row: start the next one now
                     pending_nxt = 1'b0;
                     state_nxt   = ST_START;
                  end else begin
                     state_nxt = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (trig) state_nxt = ST_START;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         x          <= '0;
         wbuf       <= 1'b0;
         row        <= 8'd0;
         sl_cnt     <= 2'd0;
         scale_q    <= 1'b0;
         pending    <= 1'b0;
         prime      <= 1'b0;
         overrun    <= 1'b0;
         buf_we_q   <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= 8'd0;
      end else begin
         pending <= pending_nxt;
         prime   <= prime_nxt;

         // Every accepted pixel is written, even if a restart arrives alongside it.
         buf_we_q <= hs;
         if (hs) begin
            buf_addr_q <= (wbuf ? BUF1_BASE : '0) + ADDR_W'(x);
            buf_data_q <= lw.src_data;
         end

         if (render_start) begin
            row     <= 8'd0;
            wbuf    <= 1'b0;
            sl_cnt  <= 2'd0;
            scale_q <= pixel_scale;
         end else begin
            if (sl_tick) sl_cnt <= trig ? 2'd0 : sl_cnt + 2'd1;
            if (state == ST_START) begin
               x <= '0;
            end else if (hs) begin
               x <= row_done ? '0 : x + X_W'(1);
               if (row_done) begin
                  wbuf <= ~wbuf;
                  row  <= row_inc;
               end
            end
         end

         if (frame_clr) begin
            overrun <= 1'b0;
         end else if (late_trig) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         ovr_cnt <= 8'd0;
      end else if (frame_clr) begin
         ovr_cnt <= 8'd0;
      end else if (late_trig && (ovr_cnt != 8'hFF)) begin
         ovr_cnt <= ovr_cnt + 8'd1;
      end
   end

   assign overrun_count = ovr_cnt;
`endif

   assign lw.row_start = (state == ST_START);
   assign lw.row_index = row;
   assign lw.src_ready = (state == ST_FILL);
   assign lw.buf_we    = buf_we_q;
   assign lw.buf_addr  = buf_addr_q;
   assign lw.buf_data  = buf_data_q;
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_chroni_line_writer.sv
`timescale 1ns/1ps
// Randomised bench for chroni_line_writer against a row-level reference model.
// Latency: model predicts each buffer write one cycle after its pixel handshake.
// Backpressure: src_valid is randomised; late row periods exercise overrun.
module tb_chroni_line_writer;

   localparam int LW = 640;
   localparam int NR = 4;
   localparam int AW = 11;

   localparam int M_IDLE  = 0;
   localparam int M_START = 1;
   localparam int M_FILL  = 2;
   localparam int M_WAIT  = 3;

   logic sys_clk        = 1'b0;
   logic reset_n        = 1'b0;
   logic frame_start    = 1'b0;
   logic render_start   = 1'b0;
   logic scanline_start = 1'b0;
   logic pixel_scale    = 1'b0;
   logic busy;
   logic overrun;
`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
   logic [7:0] overrun_count;
`endif

   chroni_line_writer_if #(.ADDR_W(AW)) lw ();

   chroni_line_writer #(
      .LINE_WIDTH (LW),
      .ROWS       (NR),
      .ADDR_W     (AW)
   ) dut (
      .sys_clk        (sys_clk),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .render_start   (render_start),
      .scanline_start (scanline_start),
      .pixel_scale    (pixel_scale),
      .lw             (lw),
      .busy           (busy),
      .overrun        (overrun)
`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
      ,
      .overrun_count  (overrun_count)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int m_state, m_x, m_half, m_row, m_pulses, m_period, m_ocnt;
   bit m_pending, m_prime, m_overrun;
   bit e_we;
   int e_addr, e_data;

   function automatic void model_reset();
      m_state = M_IDLE; m_x = 0; m_half = 0; m_row = 0; m_pulses = 0;
      m_period = 2; m_ocnt = 0; m_pending = 0; m_prime = 0; m_overrun = 0;
      e_we = 0; e_addr = 0; e_data = 0;
   endfunction

   function automatic void model_step(input bit fs, input bit rs, input bit sl,
                                      input bit sc, input bit v, input int d);
      bit hs;
      bit trig;
      hs   = (m_state == M_FILL) && v;
      e_we = hs;
      if (hs) begin
         e_addr = m_half * LW + m_x;
         e_data = d;
      end
      trig = 0;
      if (sl && !rs && m_state != M_IDLE) begin
         m_pulses++;
         if (m_pulses == m_period) begin
            m_pulses = 0;
            trig = 1;
         end
      end
      if (rs) begin
         m_row = 0; m_half = 0; m_prime = 1; m_pulses = 0; m_pending = 0;
         m_period = sc ? 4 : 2;
         m_state = M_START;
      end else if (fs) begin
         m_state = M_IDLE; m_pending = 0; m_overrun = 0; m_ocnt = 0;
      end else begin
         if (trig && (m_state == M_START || m_state == M_FILL)) begin
            m_pending = 1;
            m_overrun = 1;
            if (m_ocnt < 255) m_ocnt++;
         end
         case (m_state)
            M_START: begin
               m_x = 0;
               m_state = M_FILL;
            end
            M_FILL: if (hs) begin
               m_x++;
               if (m_x == LW) begin
                  m_x = 0;
                  m_half ^= 1;
                  m_row++;
                  if (m_row == NR) m_state = M_IDLE;
                  else if (m_prime) begin m_prime = 0; m_state = M_START; end
                  else if (m_pending) begin m_pending = 0; m_state = M_START; end
                  else m_state = M_WAIT;
               end
            end
            M_WAIT: if (trig) m_state = M_START;
            default: ;
         endcase
      end
   endfunction

   task automatic compare_outputs();
      check("busy", busy, m_state != M_IDLE);
      check("src_ready", lw.src_ready, m_state == M_FILL);
      check("row_start", lw.row_start, m_state == M_START);
      if (m_state == M_START) check("row_index", lw.row_index, m_row);
      check("buf_we", lw.buf_we, e_we);
      if (e_we) begin
         check("buf_addr", lw.buf_addr, e_addr);
         check("buf_data", lw.buf_data, e_data);
      end
      check("overrun", overrun, m_overrun);
`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
      check("overrun_count", overrun_count, m_ocnt);
`endif
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_row_start"}, lw.row_start, 0);
      check({pfx, "_row_index"}, lw.row_index, 0);
      check({pfx, "_src_ready"}, lw.src_ready, 0);
      check({pfx, "_buf_we"}, lw.buf_we, 0);
      check({pfx, "_buf_addr"}, lw.buf_addr, 0);
      check({pfx, "_buf_data"}, lw.buf_data, 0);
      check({pfx, "_overrun"}, overrun, 0);
`ifdef CHRONI_LINE_WRITER_OVERRUN_CNT_EN
      check({pfx, "_overrun_count"}, overrun_count, 0);
`endif
   endtask

   // One clock: drive inputs, advance DUT and model, compare after the edge.
   task automatic step(input bit fs, input bit rs, input bit sl, input bit v, input logic [7:0] d);
      frame_start    = fs;
      render_start   = rs;
      scanline_start = sl;
      lw.src_valid   = v;
      lw.src_data    = d;
      @(posedge sys_clk);
      if (reset_n) model_step(fs, rs, sl, pixel_scale, v, int'(d));
      else model_reset();
      #1;
      compare_outputs();
      frame_start    = 1'b0;
      render_start   = 1'b0;
      scanline_start = 1'b0;
   endtask

   task automatic run_frame(input bit scale, input int vpct, input int first_gap,
                            input int gmin, input int gmax, input int ncyc, input bit chaos);
      int gap;
      bit fs, rs, sl, v;
      pixel_scale = scale;
      step(0, 1, 0, 0, 8'h00);
      gap = first_gap;
      for (int c = 0; c < ncyc; c++) begin
         sl = 0;
         gap--;
         if (gap <= 0) begin
            sl  = 1;
            gap = int'($urandom_range(gmax, gmin));
         end
         v  = ($urandom_range(99, 0) < vpct);
         fs = 0;
         rs = 0;
         if (chaos) begin
            rs = ($urandom_range(1499, 0) == 0);
            fs = ($urandom_range(2499, 0) == 0);
            if ($urandom_range(499, 0) == 0) pixel_scale = ~pixel_scale;
         end
         step(fs, rs, sl, v, 8'($urandom));
      end
      step(1, 0, 0, 0, 8'h00);
   endtask

   initial begin
      model_reset();
      lw.src_valid = 1'b0;
      lw.src_data  = 8'h00;
      repeat (3) @(posedge sys_clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // unscaled rows, stream never stalls, periods long enough: no overrun
      run_frame(0, 100, 1400, 400, 420, 5200, 0);
      // scaled rows with mild stalls
      run_frame(1, 80, 1800, 250, 300, 6500, 0);
      // slow source, fast periods: overrun and pending restarts
      run_frame(0, 40, 100, 300, 400, 6000, 0);

      // simultaneous control pulses
      pixel_scale = 0;
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 8'($urandom));
      step(1, 1, 1, 1, 8'h5A);
      for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 8'($urandom));
      step(0, 1, 1, 1, 8'hA5);
      for (int i = 0; i < 50; i++) step(0, 0, (i % 3) == 0, 1, 8'($urandom));
      step(1, 0, 0, 0, 8'h00);

      // stalled source with a scanline every cycle drives the overrun count to saturation
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 600; i++) step(0, 0, 1, 0, 8'($urandom));
      step(1, 0, 0, 0, 8'h00);

      // random control traffic
      for (int f = 0; f < 3; f++)
         run_frame(1'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(2000, 50)),
                   100, 600, 5000, 1);

      // asynchronous reset at pixel 100 of row 1
      pixel_scale = 0;
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 3000 && !(m_state == M_FILL && m_row == 1 && m_x == 100); i++)
         step(0, 0, 0, 1, 8'($urandom));
      check("reached_row1_x100", (m_state == M_FILL && m_row == 1 && m_x == 100), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'($urandom));
      reset_n = 1'b1;
      for (int i = 0; i < 300; i++) step((i % 97) == 0, 0, (i % 5) == 0, 1, 8'($urandom));
      run_frame(0, 90, 1500, 380, 450, 3000, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/chroni_line_writer.md
Name: chroni_line_writer

Overview:
- sys_clk-domain producer for the VGA double line buffer (entries 0..LINE_WIDTH-1 = buffer 0, LINE_WIDTH..2*LINE_WIDTH-1 = buffer 1).
- Consumes the already-synchronised frame_start / render_start / scanline_start pulses and the pixel_scale level from the VGA timing block.
- Pulls one row of pixels from an upstream renderer over a valid/ready stream and writes the row into whichever buffer half the display is not scanning.
- Two rows are primed at render start; afterwards one row is written per display row period.

Parameters:
LINE_WIDTH, 640, pixels per row; also the base address of buffer 1
ROWS, 240, rows written per frame before going idle
ADDR_W, 11, line buffer address width

Ports:
sys_clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse, start of frame
render_start  in  1  single-cycle pulse, 3 lines before the playfield
scanline_start  in  1  single-cycle pulse, end of each VGA line
pixel_scale  in  1  level; 1 = 4 scanlines per row, 0 = 2 scanlines per row
row_start  out  1  single-cycle pulse, upstream must begin row row_index
row_index  out  8  row being requested (0..ROWS-1)
src_data  in  8  pixel from upstream
src_valid  in  1  src_data valid
src_ready  out  1  writer accepts src_data
buf_we  out  1  line buffer write enable
buf_addr  out  ADDR_W  line buffer write address
buf_data  out  8  line buffer write data
busy  out  1  state != IDLE
overrun  out  1  sticky; row period elapsed before row completed

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0; x=0, wbuf=0, row=0, sl_cnt=0, pending=0, prime=0.
- States: IDLE, START, FILL, WAIT.
- Period P = pixel_scale ? 4 : 2, sampled at render_start and held for the frame.
- render_start, in any state: row=0, wbuf=0, prime=1, sl_cnt=0, pending=0, go to START.
- START (1 cycle): row_start=1, row_index=row, x=0, go to FILL.
- FILL: src_ready=1.
  - Handshake when src_valid && src_ready.
  - The cycle after each handshake: buf_we=1, buf_addr=(wbuf?LINE_WIDTH:0)+x (ADDR_W bits), buf_data=captured pixel. Write latency is exactly 1 cycle.
  - x increments per handshake. On the handshake with x==LINE_WIDTH-1: wbuf toggles, row increments.
  - Next state after that handshake:
    - row (new value) == ROWS: go to IDLE.
    - Else, prime=1: prime<=0, go to START (second priming row into buffer 1).
    - Else, pending=1: pending<=0, go to START.
    - Else: go to WAIT.
- scanline_start, any state except IDLE:
  - sl_cnt increments. When sl_cnt==P-1: sl_cnt=0 and trigger fires.
  - Trigger in WAIT: go to START.
  - Trigger in START/FILL: pending=1, overrun=1.
  - Trigger while pending already 1: extra triggers are dropped; overrun stays 1.
  - The first trigger after priming is consumed like any other.
- frame_start: go to IDLE, clear pending, clear overrun. A write already registered still completes next cycle.
- Simultaneous events:
  - render_start with frame_start: render_start wins.
  - render_start with scanline_start: sl_cnt reset to 0; the pulse is not counted.
- Reset mid-row: immediate return to reset values; no further buf_we.
- src_valid while not in FILL: ignored (src_ready=0).
- No write ever targets the buffer currently displayed once the pipeline is in steady state (wbuf alternates per row).

Optional Feature:
CHRONI_LINE_WRITER_OVERRUN_CNT_EN
- Defined: adds output overrun_count[7:0]. Increments on every trigger that arrives in START/FILL, saturates at 255, clears on frame_start and on reset.
- Not defined: port absent; only the sticky overrun bit exists.

Test Plan:
- Row writes, unscaled: pixel_scale=0, render_start, src_valid held 1 with data=x[7:0] -> row_start with row_index 0; 640 writes to addr 0..639; then row_start with row_index 1; writes to addr 640..1279; busy=1; state WAIT.
- Row timing, unscaled: after priming, 2 scanline_start pulses -> row 2 written to addr 0..639; 2 more pulses -> row 3 to addr 640..1279.
- Scaled mode: pixel_scale=1 -> 3 pulses leave WAIT unchanged; the 4th starts row 2.
- Overrun: src_valid=0 during row 2 while 2 pulses arrive -> overrun=1, pending. Resume src_valid -> row 3 starts immediately after row 2's last write. With macro, overrun_count=1.
- End of frame: ROWS=4 -> after row 3 completes, busy=0 and further scanline_start pulses produce no row_start. frame_start clears overrun.
- Async reset asserted at x=100 of row 1 -> all outputs 0 the same cycle; buf_we stays 0 until the next render_start.
